// File: rtl/fpu_mul_mantissa_seq.sv
// Multi-cycle FP32 significand multiplier feeding the multiply rounding stage.
// Shift-add datapath retiring BITS_PER_CYCLE multiplier bits per cycle. It then
// normalises the 2*MANT_W product and reports {L,R,S} for the rounder.
//
// Ports:
//   clk_i, reset_i          clock, asynchronous active-low reset
//   start_i / ready_o       request handshake (accepted in IDLE only)
//   flush_i                 synchronous abort back to IDLE
//   sign/exp/mant_{a,b}_i   unpacked normal-or-zero operands (hidden bit at MSB)
//   valid_o / ready_i       result handshake
//   sign_o, exp_o           result sign, unbounded signed exponent (EXP_W+2 bits)
//   mant_o, lrs_o, zero_o   truncated normalised significand, {L,R,S}, zero flag
module fpu_mul_mantissa_seq #(
    parameter int unsigned MANT_W         = 24,
    parameter int unsigned EXP_W          = 8,
    parameter int unsigned BIAS           = 127,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                start_i,
    input  logic                flush_i,
    input  logic                sign_a_i,
    input  logic                sign_b_i,
    input  logic [EXP_W-1:0]    exp_a_i,
    input  logic [EXP_W-1:0]    exp_b_i,
    input  logic [MANT_W-1:0]   mant_a_i,
    input  logic [MANT_W-1:0]   mant_b_i,
    output logic                ready_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic                sign_o,
    output logic [EXP_W+1:0]    exp_o,
    output logic [MANT_W-1:0]   mant_o,
    output logic [2:0]          lrs_o,
    output logic                zero_o
);

    localparam int unsigned P_W   = 2 * MANT_W;
    localparam int unsigned XE_W  = EXP_W + 2;
    localparam int unsigned N_CYC = MANT_W / BITS_PER_CYCLE;
    localparam int unsigned CNT_W = $clog2(N_CYC + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_NORM = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [P_W-1:0]    a_q;       // multiplicand, pre-shifted to the current group weight
    logic [MANT_W-1:0] b_q;       // remaining multiplier bits, consumed LSB first
    logic [P_W-1:0]    p_q;       // exact partial sum of retired groups
    logic [P_W-1:0]    p_sum;
    logic [CNT_W-1:0]  cnt_q;
    logic              sgn_q;
    logic [XE_W-1:0]   exp_q;
    logic              zero_q;
    logic              in_zero;
    logic              last_grp;

    assign in_zero  = (mant_a_i == '0) || (mant_b_i == '0);
    assign last_grp = (cnt_q == CNT_W'(N_CYC - 1));

    // Partial sum after retiring the current group of multiplier bits
    always_comb begin
        p_sum = p_q;
        for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
            if (b_q[i]) begin
                p_sum = p_sum + (a_q << i);
            end
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start_i)  state_d = S_MUL;
            S_MUL:  if (last_grp) state_d = S_NORM;
            S_NORM: state_d = S_DONE;
            S_DONE: if (ready_i)  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush_i) begin
            state_d = S_IDLE;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            ready_o <= 1'b1;
            valid_o <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
            exp_q   <= '0;
            zero_q  <= 1'b0;
            sign_o  <= 1'b0;
            exp_o   <= '0;
            mant_o  <= '0;
            lrs_o   <= '0;
            zero_o  <= 1'b0;
        end else begin
            ready_o <= (state_d == S_IDLE);
            valid_o <= (state_d == S_DONE);
            case (state_q)
                S_IDLE: begin
                    if (start_i && !flush_i) begin
                        a_q    <= P_W'(mant_a_i);
                        p_q    <= '0;
                        sgn_q  <= sign_a_i ^ sign_b_i;
                        exp_q  <= XE_W'(exp_a_i) + XE_W'(exp_b_i) - XE_W'(BIAS);
                        zero_q <= in_zero;
                        // A zero operand makes a single empty pass so its latency is a fixed 2
                        b_q    <= in_zero ? '0 : mant_b_i;
                        cnt_q  <= in_zero ? CNT_W'(N_CYC - 1) : '0;
                    end
                end
                S_MUL: begin
                    p_q   <= p_sum;
                    a_q   <= a_q << BITS_PER_CYCLE;
                    b_q   <= b_q >> BITS_PER_CYCLE;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                S_NORM: begin
                    if (!flush_i) begin
                        sign_o <= sgn_q;
                        if (zero_q) begin
                            mant_o <= '0;
                            lrs_o  <= 3'b000;
                            zero_o <= 1'b1;
                            exp_o  <= exp_q;
                        end else if (p_q[P_W-1]) begin
                            mant_o <= p_q[P_W-1 -: MANT_W];
                            lrs_o  <= {p_q[MANT_W], p_q[MANT_W-1], |p_q[MANT_W-2:0]};
                            zero_o <= 1'b0;
                            exp_o  <= exp_q + XE_W'(1);
                        end else begin
                            mant_o <= p_q[P_W-2 -: MANT_W];
                            lrs_o  <= {p_q[MANT_W-1], p_q[MANT_W-2], |p_q[MANT_W-3:0]};
                            zero_o <= 1'b0;
                            exp_o  <= exp_q;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_mul_mantissa_seq.sv
// Bench for fpu_mul_mantissa_seq: two instances (1 and 4 bits per cycle) share
// operands, each with its own start/flush/ready and its own scoreboard queue.
module tb_fpu_mul_mantissa_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start_w [2];
    logic        flush_w [2];
    logic        rdy_w   [2];
    logic        sign_a, sign_b;
    logic [7:0]  exp_a, exp_b;
    logic [23:0] mant_a, mant_b;

    logic        ready_w [2];
    logic        valid_w [2];
    logic        sign_w  [2];
    logic        zero_w  [2];
    logic [9:0]  exp_w   [2];
    logic [23:0] mant_w  [2];
    logic [2:0]  lrs_w   [2];

    fpu_mul_mantissa_seq #(.BITS_PER_CYCLE(1)) dut0 (
        .clk_i(clk), .reset_i(rst_n), .start_i(start_w[0]), .flush_i(flush_w[0]),
        .sign_a_i(sign_a), .sign_b_i(sign_b), .exp_a_i(exp_a), .exp_b_i(exp_b),
        .mant_a_i(mant_a), .mant_b_i(mant_b), .ready_o(ready_w[0]), .valid_o(valid_w[0]),
        .ready_i(rdy_w[0]), .sign_o(sign_w[0]), .exp_o(exp_w[0]), .mant_o(mant_w[0]),
        .lrs_o(lrs_w[0]), .zero_o(zero_w[0])
    );

    fpu_mul_mantissa_seq #(.BITS_PER_CYCLE(4)) dut1 (
        .clk_i(clk), .reset_i(rst_n), .start_i(start_w[1]), .flush_i(flush_w[1]),
        .sign_a_i(sign_a), .sign_b_i(sign_b), .exp_a_i(exp_a), .exp_b_i(exp_b),
        .mant_a_i(mant_a), .mant_b_i(mant_b), .ready_o(ready_w[1]), .valid_o(valid_w[1]),
        .ready_i(rdy_w[1]), .sign_o(sign_w[1]), .exp_o(exp_w[1]), .mant_o(mant_w[1]),
        .lrs_o(lrs_w[1]), .zero_o(zero_w[1])
    );

    typedef struct {
        logic        sign;
        logic [9:0]  exp;
        logic [23:0] mant;
        logic [2:0]  lrs;
        logic        zero;
        int unsigned due;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t last0;

    int unsigned cyc = 0;
    int n_checks = 0;
    int n_pass   = 0;
    int hold [2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, want, cyc);
    endtask

    // Reference: exact integer product, then normalise by magnitude.
    // The due field returns the expected latency in cycles.
    function automatic exp_t model(input logic sa, input logic sb, input logic [7:0] ea,
                                   input logic [7:0] eb, input logic [23:0] ma,
                                   input logic [23:0] mb, input int unsigned bpc);
        exp_t r;
        longint unsigned p, rem;
        int e;
        p = 64'(ma) * 64'(mb);
        e = int'(ea) + int'(eb) - 127;
        r.sign = sa ^ sb;
        if (ma == 0 || mb == 0) begin
            r.zero = 1'b1; r.mant = '0; r.lrs = 3'b000; r.due = 2;
        end else begin
            r.zero = 1'b0;
            if (p >= 64'h8000_0000_0000) begin
                r.mant = 24'(p / (64'd1 << 24));
                rem    = p % (64'd1 << 24);
                e      = e + 1;
                r.lrs  = {r.mant[0], rem >= (64'd1 << 23), (rem % (64'd1 << 23)) != 0};
            end else begin
                r.mant = 24'(p / (64'd1 << 23));
                rem    = p % (64'd1 << 23);
                r.lrs  = {r.mant[0], rem >= (64'd1 << 22), (rem % (64'd1 << 22)) != 0};
            end
            r.due = 24 / bpc + 1;
        end
        r.exp = 10'(e);
        return r;
    endfunction

    // Monitor: compares every valid cycle against the queue head and drives ready_i
    initial begin
        logic prev_v [2];
        logic hs [2];
        logic new_rdy;
        exp_t h;
        prev_v[0] = 0; prev_v[1] = 0; hs[0] = 0; hs[1] = 0;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (!rst_n) begin
                    rdy_w[d] = 1'b0; prev_v[d] = 1'b0; hs[d] = 1'b0;
                    continue;
                end
                if (hs[d]) begin
                    chk($sformatf("ready_after_hs_dut%0d", d), 64'(ready_w[d]), 64'd1);
                    chk($sformatf("valid_after_hs_dut%0d", d), 64'(valid_w[d]), 64'd0);
                end
                hs[d] = 1'b0;
                new_rdy = ($urandom_range(0, 3) != 0);
                if (valid_w[d]) begin
                    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                        chk($sformatf("unexpected_valid_dut%0d", d), 64'd1, 64'd0);
                    end else begin
                        h = (d == 0) ? q0[0] : q1[0];
                        if (!prev_v[d])
                            chk($sformatf("latency_dut%0d", d), 64'(cyc), 64'(h.due));
                        chk($sformatf("mant_dut%0d", d), 64'(mant_w[d]), 64'(h.mant));
                        chk($sformatf("exp_dut%0d", d),  64'(exp_w[d]),  64'(h.exp));
                        chk($sformatf("lrs_dut%0d", d),  64'(lrs_w[d]),  64'(h.lrs));
                        chk($sformatf("sign_dut%0d", d), 64'(sign_w[d]), 64'(h.sign));
                        chk($sformatf("zero_dut%0d", d), 64'(zero_w[d]), 64'(h.zero));
                        chk($sformatf("ready_in_done_dut%0d", d), 64'(ready_w[d]), 64'd0);
                        if (hold[d] > 0) begin
                            new_rdy = 1'b0;
                            hold[d]--;
                        end
                        if (new_rdy) begin
                            if (d == 0) void'(q0.pop_front());
                            else        void'(q1.pop_front());
                            hs[d] = 1'b1;
                        end
                    end
                end
                prev_v[d] = valid_w[d];
                rdy_w[d]  = new_rdy;
            end
        end
    end

    task automatic wait_ready(input int d);
        int n = 0;
        while (!ready_w[d] && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("wait_ready_dut%0d", d), 64'(ready_w[d]), 64'd1);
    endtask

    task automatic issue(input bit m0, input bit m1, input bit push, input logic sa,
                         input logic sb, input logic [7:0] ea, input logic [7:0] eb,
                         input logic [23:0] ma, input logic [23:0] mb);
        exp_t e;
        @(negedge clk);
        if (m0) wait_ready(0);
        if (m1) wait_ready(1);
        sign_a = sa; sign_b = sb; exp_a = ea; exp_b = eb; mant_a = ma; mant_b = mb;
        if (m0) begin
            e = model(sa, sb, ea, eb, ma, mb, 1);
            e.due = e.due + cyc + 1;
            if (push) begin q0.push_back(e); last0 = e; end
            start_w[0] = 1'b1;
        end
        if (m1) begin
            e = model(sa, sb, ea, eb, ma, mb, 4);
            e.due = e.due + cyc + 1;
            if (push) q1.push_back(e);
            start_w[1] = 1'b1;
        end
        @(posedge clk);
        #1;
        start_w[0] = 1'b0;
        start_w[1] = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || !ready_w[0] || !ready_w[1]) && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk("drain_q0", 64'(q0.size()), 64'd0);
        chk("drain_q1", 64'(q1.size()), 64'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_ready_dut%0d", tag, d), 64'(ready_w[d]), 64'd1);
            chk($sformatf("%s_valid_dut%0d", tag, d), 64'(valid_w[d]), 64'd0);
            chk($sformatf("%s_mant_dut%0d", tag, d),  64'(mant_w[d]),  64'd0);
            chk($sformatf("%s_exp_dut%0d", tag, d),   64'(exp_w[d]),   64'd0);
            chk($sformatf("%s_lrs_dut%0d", tag, d),   64'(lrs_w[d]),   64'd0);
            chk($sformatf("%s_zero_dut%0d", tag, d),  64'(zero_w[d]),  64'd0);
            chk($sformatf("%s_sign_dut%0d", tag, d),  64'(sign_w[d]),  64'd0);
        end
    endtask

    initial begin
        int n;
        logic [23:0] ma, mb;
        rst_n = 1'b0;
        start_w[0] = 0; start_w[1] = 0; flush_w[0] = 0; flush_w[1] = 0;
        rdy_w[0] = 0; rdy_w[1] = 0; hold[0] = 0; hold[1] = 0;
        sign_a = 0; sign_b = 0; exp_a = 0; exp_b = 0; mant_a = 0; mant_b = 0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;

        // Directed operand cases on both instances
        issue(1, 1, 1, 0, 0, 8'd127, 8'd127, 24'h800000, 24'h800000);
        issue(1, 1, 1, 0, 1, 8'd127, 8'd127, 24'hC00000, 24'hC00000);
        issue(1, 1, 1, 1, 1, 8'd127, 8'd127, 24'h800001, 24'hC00000);
        issue(1, 1, 1, 0, 0, 8'd127, 8'd127, 24'hFFFFFF, 24'hFFFFFF);
        issue(1, 1, 1, 1, 0, 8'd100, 8'd90,  24'hA00000, 24'h000000);
        issue(1, 1, 1, 0, 0, 8'd1,   8'd1,   24'h812345, 24'h9ABCDE);
        issue(1, 1, 1, 1, 0, 8'd254, 8'd254, 24'hFEDCBA, 24'hF00001);
        drain();

        // Backpressure: ready_i held low 5 cycles in DONE while start_i pulses
        hold[0] = 5;
        issue(1, 0, 1, 0, 1, 8'd130, 8'd120, 24'hA00000, 24'hB00000);
        n = 0;
        while (!valid_w[0] && n < 100) begin @(negedge clk); n++; end
        chk("bp_valid_seen", 64'(valid_w[0]), 64'd1);
        mant_a = 24'hFFFFFF; mant_b = 24'h812345; start_w[0] = 1'b1;
        repeat (4) @(negedge clk);
        start_w[0] = 1'b0;
        drain();

        // Flush at MUL cycle 10: back to IDLE, no result, data outputs retained
        issue(1, 0, 0, 0, 0, 8'd127, 8'd127, 24'hC00000, 24'hE00000);
        repeat (9) @(negedge clk);
        flush_w[0] = 1'b1;
        @(posedge clk);
        #1;
        flush_w[0] = 1'b0;
        chk("flush_ready", 64'(ready_w[0]), 64'd1);
        chk("flush_valid", 64'(valid_w[0]), 64'd0);
        repeat (40) @(negedge clk);
        chk("flush_no_valid", 64'(valid_w[0]), 64'd0);
        chk("flush_keeps_mant", 64'(mant_w[0]), 64'(last0.mant));
        chk("flush_keeps_exp",  64'(exp_w[0]),  64'(last0.exp));

        // Asynchronous reset mid-MUL
        issue(1, 1, 0, 0, 0, 8'd127, 8'd127, 24'hFFFFFF, 24'hFFFFFF);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_vals("midreset");
        @(negedge clk);
        rst_n = 1'b1;

        // Randomised operands, occasional zero significand
        for (int t = 0; t < 40; t++) begin
            ma = 24'($urandom) | 24'h800000;
            mb = 24'($urandom) | 24'h800000;
            if ($urandom_range(0, 7) == 0) ma = '0;
            if ($urandom_range(0, 7) == 0) mb = '0;
            issue(1, 1, 1, 1'($urandom), 1'($urandom), 8'($urandom_range(1, 254)),
                  8'($urandom_range(1, 254)), ma, mb);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
